// File: rtl/syn_addr_seq.sv
// Strided read / delayed write-back address sequencer for a Synapse row.
// Optional acc_clr output is built when SYN_SEQ_ACCLR_EN is defined.
module syn_addr_seq #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_r,
    input  logic [ADDR_W-1:0] base_w,
    input  logic [ADDR_W-1:0] stride,
    input  logic [LEN_W-1:0]  len,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic              rd_vld,
    output logic [ADDR_W-1:0] r_addr,
    output logic [ADDR_W-1:0] w_addr,
`ifdef SYN_SEQ_ACCLR_EN
    output logic              acc_clr,
`endif
    output logic              we_ram
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state, state_n;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   rd_cnt;
    logic [ADDR_W-1:0]  stride_q;
    logic [ADDR_W-1:0]  w_ptr;
    logic               rd_vld_q;
    logic [LAT:1]       sh;
    logic [LAT:0]       tap;
    logic               hold;

    assign hold = stall && (state == RUN || state == DRAIN);
    assign tap  = {sh, rd_vld_q};

    // Strobes are registered but masked by stall in the same cycle, so a
    // stalled cycle shows no read/write and the pending one re-issues next.
    assign rd_vld = rd_vld_q && !hold;
    assign we_ram = sh[LAT] && !hold;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = (len == '0) ? DONE : RUN;
            RUN:     if (!hold && rd_cnt == len_q) state_n = DRAIN;
            DRAIN:   if (!hold && tap[LAT-1:0] == '0) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_vld_q <= 1'b0;
            r_addr   <= '0;
            w_addr   <= '0;
            w_ptr    <= '0;
            len_q    <= '0;
            rd_cnt   <= '0;
            stride_q <= '0;
            sh       <= '0;
        end else begin
            if (!hold) begin
                sh <= tap[LAT-1:0];
                if (tap[LAT-1]) begin
                    w_addr <= w_ptr;
                    w_ptr  <= w_ptr + 1'b1;
                end
            end
            case (state)
                IDLE: if (start) begin
                    len_q    <= len;
                    stride_q <= stride;
                    w_ptr    <= base_w;
                    if (len != '0) begin
                        r_addr   <= base_r;
                        rd_vld_q <= 1'b1;
                        rd_cnt   <= LEN_W'(1);
                        busy     <= 1'b1;
                    end else begin
                        done <= 1'b1;
                    end
                end
                RUN: if (!hold) begin
                    if (rd_cnt == len_q) begin
                        rd_vld_q <= 1'b0;
                    end else begin
                        r_addr <= r_addr + stride_q;
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end
                DRAIN: if (!hold && tap[LAT-1:0] == '0) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                DONE:    done <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef SYN_SEQ_ACCLR_EN
    logic acc_q;
    assign acc_clr = acc_q && !hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   acc_q <= 1'b0;
        else if (state == IDLE && start && len != '0) acc_q <= 1'b1;
        else if (state == RUN && !hold)            acc_q <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_syn_addr_seq.sv
// Directed scoreboard bench for syn_addr_seq (default and SYN_SEQ_ACCLR_EN builds).
module tb_syn_addr_seq;

`ifdef SYN_SEQ_ACCLR_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] base_r = '0, base_w = '0, stride = '0, len = '0;
    logic       stall = 1'b0;
    logic       busy, done, rd_vld, we_ram;
    logic [7:0] r_addr, w_addr;
    logic       acc_obs;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       busy, done, rd, we, acc;
        logic [7:0] ra, wa;
    } exp_t;

    exp_t exp_q[$];

    syn_addr_seq #(.ADDR_W(8), .LEN_W(8), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start),
        .base_r(base_r), .base_w(base_w), .stride(stride), .len(len),
        .stall(stall), .busy(busy), .done(done), .rd_vld(rd_vld),
        .r_addr(r_addr), .w_addr(w_addr),
`ifdef SYN_SEQ_ACCLR_EN
        .acc_clr(acc_obs),
`endif
        .we_ram(we_ram)
    );

`ifndef SYN_SEQ_ACCLR_EN
    assign acc_obs = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".done"}, 32'(done), 0);
        chk({tag, ".rd_vld"}, 32'(rd_vld), 0);
        chk({tag, ".we_ram"}, 32'(we_ram), 0);
        chk({tag, ".acc_clr"}, 32'(acc_obs), 0);
    endtask

    // Expected trace follows the documented timing: read k at effective
    // cycle 1+k, write k at 1+k+LAT, done at len+LAT+1; stall cycle s is blank.
    task automatic run(input string name, input logic [7:0] br, input logic [7:0] st,
                       input logic [7:0] bw, input logic [7:0] ln,
                       input int s, input int ign);
        exp_t x;
        int   e = 0, t = 0;
        bit   fin = 0;
        while (!fin) begin
            t++;
            x = '{default: 0};
            if (t == s) begin
                x.busy = 1'b1;
            end else begin
                e++;
                if (ln == 0) begin
                    x.done = 1'b1;
                    fin = 1;
                end else begin
                    x.rd   = (e <= int'(ln));
                    x.ra   = br + 8'(int'(st) * (e - 1));
                    x.we   = (e >= 1 + LAT) && (e <= int'(ln) + LAT);
                    x.wa   = bw + 8'(e - 1 - LAT);
                    x.busy = (e <= int'(ln) + LAT);
                    x.acc  = (e == 1);
                    if (e == int'(ln) + LAT + 1) begin
                        x.done = 1'b1;
                        fin = 1;
                    end
                end
            end
            exp_q.push_back(x);
        end
        exp_q.push_back('{default: 0});

        base_r = br; stride = st; base_w = bw; len = ln; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; exp_q.size() > 0; c++) begin
            stall = (c == s);
            if (c == ign) begin
                start = 1'b1; base_r = 8'hAA; stride = 8'h07; base_w = 8'h55; len = 8'd1;
            end
            @(negedge clk);
            x = exp_q.pop_front();
            chk($sformatf("%s.c%0d.busy", name, c), 32'(busy), 32'(x.busy));
            chk($sformatf("%s.c%0d.done", name, c), 32'(done), 32'(x.done));
            chk($sformatf("%s.c%0d.rd_vld", name, c), 32'(rd_vld), 32'(x.rd));
            chk($sformatf("%s.c%0d.we_ram", name, c), 32'(we_ram), 32'(x.we));
            if (x.rd) chk($sformatf("%s.c%0d.r_addr", name, c), 32'(r_addr), 32'(x.ra));
            if (x.we) chk($sformatf("%s.c%0d.w_addr", name, c), 32'(w_addr), 32'(x.wa));
`ifdef SYN_SEQ_ACCLR_EN
            chk($sformatf("%s.c%0d.acc_clr", name, c), 32'(acc_obs), 32'(x.acc));
`endif
            if (exp_q.size() > 0) begin
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        stall = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        #2;
        chk_idle("reset");
        chk("reset.r_addr", 32'(r_addr), 0);
        chk("reset.w_addr", 32'(w_addr), 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);

        run("basic", 8'h10, 8'd2, 8'h40, 8'd4, 0, 0);
        run("wrap",  8'hFE, 8'd1, 8'hFF, 8'd3, 0, 0);
        run("zero",  8'h33, 8'd5, 8'h66, 8'd0, 0, 0);
        run("stall", 8'h20, 8'd3, 8'h80, 8'd4, 3, 0);
        run("drain_stall", 8'h01, 8'd1, 8'h10, 8'd2, 2 + LAT, 0);

        // Reset mid-run: len=8, rst raised in cycle 3.
        base_r = 8'h50; stride = 8'd1; base_w = 8'h90; len = 8'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("rstrun.c2.rd_vld", 32'(rd_vld), 1);
        chk("rstrun.c2.r_addr", 32'(r_addr), 32'h51);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk_idle("rstrun.c3");
        chk("rstrun.c3.r_addr", 32'(r_addr), 0);
        chk("rstrun.c3.w_addr", 32'(w_addr), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_idle($sformatf("postrst.%0d", i));
        end

        run("ignstart", 8'h05, 8'h10, 8'h00, 8'd5, 0, 2);
        run("back2back", 8'hC0, 8'hFF, 8'hFE, 8'd3, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
